mdiv_div_unit: RTL
==================

Name: mdiv_div_unit

Overview:
- Iterative integer divide execution unit. Slave side of the pipeline→EXU mdiv channel (data1, data2, opcode, funct, itag, valid, full).
- Executes RV64M DIV/DIVU/REM/REMU and the W variants with a radix-2 restoring divider.
- Drives one result at a time to the writeback/commit stage through a valid/full handshake.

Parameters:
- XLEN, 64, operand/result width (from prv664_config).
- ITAG_W, 8, instruction tag width.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; aborts any in-flight op
- mdiv_valid_i  in  1  request valid
- mdiv_full_o  out  1  unit cannot accept (mdiv_sif.full)
- mdiv_itag_i  in  ITAG_W  instruction tag
- mdiv_opcode_i  in  5  5'b01100 = OP (64-bit), 5'b01110 = OP-32 (W variant)
- mdiv_funct_i  in  10  {funct7, funct3}; funct3 100 DIV, 101 DIVU, 110 REM, 111 REMU
- mdiv_data1_i  in  XLEN  dividend (rs1)
- mdiv_data2_i  in  XLEN  divisor (rs2)
- wb_valid_o  out  1  result valid
- wb_itag_o  out  ITAG_W  tag of result
- wb_data_o  out  XLEN  result
- wb_full_i  in  1  downstream stall

Behaviour:
- Clock/reset: one clock, clk_i. Reset arst_ni is asynchronous, active-low.
- Reset values: state IDLE, mdiv_full_o=0, wb_valid_o=0, wb_itag_o=0, wb_data_o=0, all internal registers 0.
- FSM states: IDLE, BUSY, DONE. mdiv_full_o = (state != IDLE), registered-state based with no combinational path from inputs.
- Accept: mdiv_valid_i && state==IDLE latches itag, op kind (signed, rem, word) and operands.
- Operand prep:
  - W variant: low 32 bits, sign-extended if signed, else zero-extended.
  - Signed ops: divide magnitudes; record quotient sign = s1^s2 and remainder sign = s1.
- Special cases go IDLE→DONE in one cycle, no BUSY:
  - Divisor == 0: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = most-negative of the op width, divisor = -1): quotient = dividend, remainder = 0.
- Normal path: BUSY for K cycles, K = 64 (OP) or 32 (OP-32). Each cycle shifts the {rem, quo} pair left by 1 and subtracts the divisor if no borrow; counter counts K-1 down to 0.
- On counter==0, BUSY→DONE. That transition applies sign correction (two's-complement negate) and W sign-extension of bit 31 to XLEN, then registers wb_data_o.
- Latency: accepted at cycle t → wb_valid_o first high at t+K+1 (normal), t+1 (special cases).
- DONE: wb_valid_o=1, holds wb_data_o/wb_itag_o stable while wb_full_i=1.
  - Cycle with wb_full_i=0 completes the transfer → IDLE next cycle (wb_valid_o=0).
  - No back-to-back bypass: a new request is accepted no earlier than the cycle after return to IDLE.
- Illegal funct3 (bit2=0, i.e. multiply codes) or other opcode: accepted, returns 0 via DONE in one cycle (defensive; dispatch never routes these here).
- flush_i: highest priority. Any state → IDLE next cycle, wb_valid_o=0, counter cleared. A request presented in the flush cycle is not accepted.
- Reset mid-operation: immediate return to reset values; no partial result is ever emitted.

Decomposition:
- Shared package (prv664 define): opcode constants OP/OP-32, funct3 codes DIV/DIVU/REM/REMU, FSM state enum.
- One natural sub-module: div_core_radix2. Contains the shift/subtract datapath and the counter, with start/done signals. The top keeps the FSM, operand prep, special cases, sign fix-up and handshake.

Test Plan:
- DIV 64-bit: data1=-7, data2=2, itag=8'h15 → wb_data=-3 (0xFFFF_FFFF_FFFF_FFFD), itag 8'h15, wb_valid exactly 65 cycles after accept; REM same operands → -1.
- DIVUW: data1=0xFFFF_FFFF_8000_0000, data2=2 → wb_data=0x0000_0000_4000_0000 (sign-ext of bit31=0), latency 33.
- Divide by zero: DIVU data1=0x1234, data2=0 → 0xFFFF_FFFF_FFFF_FFFF; REMU → 0x1234; both with latency 1.
- Overflow: DIV data1=0x8000_0000_0000_0000, data2=-1 → quotient 0x8000_0000_0000_0000, REM → 0; DIVW data1=0x8000_0000, data2=-1 → 0xFFFF_FFFF_8000_0000.
- Backpressure: hold wb_full_i=1 for 10 cycles in DONE → wb_valid/data/itag stable, mdiv_full_o=1 throughout, a second request held on mdiv_valid_i is not accepted until the cycle after the transfer.
- Flush/reset: assert flush_i at BUSY count 20 → IDLE next cycle, no wb_valid; new DIVU 100/7 then yields 14. Drop arst_ni mid-BUSY → all outputs 0 asynchronously.

Source files
------------

// File: rtl/mdiv_div_unit_pkg.sv
// Shared definitions for the mdiv divide unit: opcode/funct3 codes, FSM state
// encodings and the per-instruction decode helpers.
package mdiv_div_unit_pkg;

  localparam int MDIV_XLEN   = 64;
  localparam int MDIV_ITAG_W = 8;

  localparam logic [4:0] OPC_OP   = 5'b01100;
  localparam logic [4:0] OPC_OP32 = 5'b01110;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
    logic is_word;
  } op_kind_t;

  function automatic op_kind_t decode_kind(input logic [2:0] f3, input logic is_word);
    op_kind_t k;
    k.is_signed = (f3 == F3_DIV) || (f3 == F3_REM);
    k.is_rem    = (f3 == F3_REM) || (f3 == F3_REMU);
    k.is_word   = is_word;
    return k;
  endfunction

  // Multiply codes and foreign opcodes are tolerated but produce a zero result.
  function automatic logic is_legal(input logic [4:0] opcode, input logic [2:0] f3);
    logic opc_ok;
    logic f3_ok;
    opc_ok = (opcode == OPC_OP) || (opcode == OPC_OP32);
    f3_ok  = (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    return opc_ok && f3_ok;
  endfunction

endpackage

// File: rtl/mdiv_div_unit_div_core_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle.
// quo_o/rem_o are the results of the step being taken this cycle; last_o marks the final step.
module mdiv_div_unit_div_core_radix2 #(
  parameter int XLEN = 64,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [CW-1:0]   count_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;

  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] diff;
  logic            take;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] rem_step;

  // The shifted partial remainder may reach XLEN+1 bits; when it does the
  // subtraction always succeeds and the difference fits back into XLEN bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    take      = rem_shift >= {1'b0, dvsr_q};
    diff      = rem_shift[XLEN-1:0] - dvsr_q;
    rem_step  = take ? diff : rem_shift[XLEN-1:0];
    quo_step  = {quo_q[XLEN-2:0], take};
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (clear_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = count_i;
      quo_d  = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (busy_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign last_o = busy_q && (cnt_q == '0);
  assign quo_o  = quo_step;
  assign rem_o  = rem_step;

endmodule

// File: rtl/mdiv_div_unit.sv
// RV64M divide/remainder execution unit: decodes and prepares operands, resolves
// special cases directly, runs the iterative core otherwise and hands results to writeback.
module mdiv_div_unit
  import mdiv_div_unit_pkg::*;
#(
  parameter int XLEN   = MDIV_XLEN,
  parameter int ITAG_W = MDIV_ITAG_W
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              flush_i,
  input  logic              mdiv_valid_i,
  output logic              mdiv_full_o,
  input  logic [ITAG_W-1:0] mdiv_itag_i,
  input  logic [4:0]        mdiv_opcode_i,
  input  logic [9:0]        mdiv_funct_i,
  input  logic [XLEN-1:0]   mdiv_data1_i,
  input  logic [XLEN-1:0]   mdiv_data2_i,
  output logic              wb_valid_o,
  output logic [ITAG_W-1:0] wb_itag_o,
  output logic [XLEN-1:0]   wb_data_o,
  input  logic              wb_full_i
);

  localparam int              CW    = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};
  localparam logic [CW-1:0]   CNT_D = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_W = CW'(31);

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [31:0] x);
    return {{(XLEN-32){1'b0}}, x};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ITAG_W-1:0] itag_q, itag_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              rem_q, rem_d;
  logic              word_q, word_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic [2:0]        f3;
  op_kind_t          kind;
  logic              legal;
  logic [XLEN-1:0]   op1, op2, mag1, mag2;
  logic              s1, s2, div_zero, ovf, special;
  logic [XLEN-1:0]   spec_res;
  logic [XLEN-1:0]   core_dvd;
  logic [CW-1:0]     core_cnt;
  logic              accept;
  logic              core_start;
  logic              core_last;
  logic [XLEN-1:0]   core_quo, core_rem;
  logic [XLEN-1:0]   res_mag, res_fix, fin_res;

  logic unused_funct7;
  assign unused_funct7 = ^mdiv_funct_i[9:3];

  // Word ops keep their 32-bit dividend in the top half of the core's shift
  // register so that 32 steps leave the quotient in the low half.
  always_comb begin
    f3    = mdiv_funct_i[2:0];
    legal = is_legal(mdiv_opcode_i, f3);
    kind  = decode_kind(f3, mdiv_opcode_i == OPC_OP32);
    if (kind.is_word) begin
      op1 = kind.is_signed ? sext_w(mdiv_data1_i[31:0]) : zext_w(mdiv_data1_i[31:0]);
      op2 = kind.is_signed ? sext_w(mdiv_data2_i[31:0]) : zext_w(mdiv_data2_i[31:0]);
    end else begin
      op1 = mdiv_data1_i;
      op2 = mdiv_data2_i;
    end
    s1       = kind.is_signed && op1[XLEN-1];
    s2       = kind.is_signed && op2[XLEN-1];
    mag1     = s1 ? -op1 : op1;
    mag2     = s2 ? -op2 : op2;
    div_zero = (op2 == '0);
    ovf      = kind.is_signed && (op1 == (kind.is_word ? MIN_W : MIN_D)) && (op2 == '1);
    special  = !legal || div_zero || ovf;

    spec_res = '0;
    if (legal) begin
      if (div_zero) begin
        spec_res = kind.is_rem ? op1 : '1;
      end else if (ovf) begin
        spec_res = kind.is_rem ? '0 : op1;
      end
    end
    if (kind.is_word) begin
      spec_res = sext_w(spec_res[31:0]);
    end

    core_dvd = kind.is_word ? (mag1 << (XLEN - 32)) : mag1;
    core_cnt = kind.is_word ? CNT_W : CNT_D;
  end

  always_comb begin
    res_mag = rem_q ? core_rem : core_quo;
    res_fix = (rem_q ? rneg_q : qneg_q) ? -res_mag : res_mag;
    fin_res = word_q ? sext_w(res_fix[31:0]) : res_fix;
  end

  assign accept = (state_q == ST_IDLE) && mdiv_valid_i && !flush_i;

  // Flush overrides every transition, including an acceptance in IDLE.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mdiv_valid_i) begin
          if (special) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_BUSY;
            core_start = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (core_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!wb_full_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d    = ST_IDLE;
      core_start = 1'b0;
    end
  end

  always_comb begin
    itag_d    = itag_q;
    wb_data_d = wb_data_q;
    rem_d     = rem_q;
    word_d    = word_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    if (accept) begin
      itag_d = mdiv_itag_i;
      rem_d  = kind.is_rem;
      word_d = kind.is_word;
      qneg_d = s1 ^ s2;
      rneg_d = s1;
      if (special) wb_data_d = spec_res;
    end
    if ((state_q == ST_BUSY) && core_last && !flush_i) begin
      wb_data_d = fin_res;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= ST_IDLE;
      itag_q    <= '0;
      wb_data_q <= '0;
      rem_q     <= 1'b0;
      word_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      itag_q    <= itag_d;
      wb_data_q <= wb_data_d;
      rem_q     <= rem_d;
      word_q    <= word_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
    end
  end

  mdiv_div_unit_div_core_radix2 #(
    .XLEN (XLEN),
    .CW   (CW)
  ) u_core (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .clear_i    (flush_i),
    .start_i    (core_start),
    .count_i    (core_cnt),
    .dividend_i (core_dvd),
    .divisor_i  (mag2),
    .last_o     (core_last),
    .quo_o      (core_quo),
    .rem_o      (core_rem)
  );

  assign mdiv_full_o = (state_q != ST_IDLE);
  assign wb_valid_o  = (state_q == ST_DONE);
  assign wb_itag_o   = itag_q;
  assign wb_data_o   = wb_data_q;

endmodule
